// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Requester-side byte streams plus the shared transmitter byte port.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_ready;
    logic               tx_ack;

    // master: the arbiter; slave: requesters plus transmitter
    modport master (
        input  req_valid, req_data, req_last, tx_ack,
        output req_ready, tx_data, tx_ready
    );
    modport slave (
        output req_valid, req_data, req_last, tx_ack,
        input  req_ready, tx_data, tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin packet arbiter sharing one UART byte transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255,
    parameter int HDR_EN    = 1
) (
    input  wire logic              sys_clk,
    input  wire logic              sys_rst_n,
    uart_tx_arbiter_if.master      arb_bus,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy
);
    localparam int C_PW = $clog2(N_REQ);
    localparam int C_BW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_hdr  = 2'd1;
    localparam logic [1:0] c_data = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [C_PW-1:0]  ptr_q,   ptr_d;
    logic [C_PW-1:0]  gid_q,   gid_d;
    logic [C_BW-1:0]  bcnt_q,  bcnt_d;
    logic [15:0]      tcnt_q,  tcnt_d;

    logic             sel_found;
    logic [C_PW-1:0]  sel_idx;
    logic [C_PW-1:0]  ptr_next;
    logic             own_valid;
    logic             own_last;
    logic [7:0]       own_data;

    assign own_valid = arb_bus.req_valid[gid_q];
    assign own_last  = arb_bus.req_last[gid_q];
    assign own_data  = arb_bus.req_data[8*int'(gid_q) +: 8];
    assign ptr_next  = (gid_q == C_PW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;

    // First valid requester at or after ptr, wrapping modulo N_REQ
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!sel_found && arb_bus.req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = C_PW'(idx);
            end
        end
    end

    always_comb begin
        arb_bus.tx_ready  = 1'b0;
        arb_bus.tx_data   = 8'h00;
        arb_bus.req_ready = '0;
        case (state_q)
            c_hdr: begin
                arb_bus.tx_ready = 1'b1;
                arb_bus.tx_data  = {5'b11110, 3'(gid_q)};
            end
            c_data: begin
                arb_bus.tx_ready         = own_valid;
                arb_bus.tx_data          = own_data;
                arb_bus.req_ready[gid_q] = arb_bus.tx_ack;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            c_idle: begin
                bcnt_d = '0;
                tcnt_d = '0;
                if (sel_found) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    gid_d            = sel_idx;
                    state_d          = (HDR_EN != 0) ? c_hdr : c_data;
                end
            end
            c_hdr: begin
                if (arb_bus.tx_ack) state_d = c_data;
            end
            c_data: begin
                if (own_valid && arb_bus.tx_ack) begin
                    bcnt_d = bcnt_q + 1'b1;
                    tcnt_d = '0;
                    if (own_last || bcnt_q == C_BW'(MAX_BURST - 1)) begin
                        state_d = c_idle;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                    end
                end else if (!own_valid) begin
                    tcnt_d = tcnt_q + 16'd1;
                    if (tcnt_q == 16'(TIMEOUT - 1)) begin
                        state_d = c_idle;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                    end
                end
            end
            default: begin
                state_d = c_idle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= c_idle;
            grant_q <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != c_idle);
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter (4 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;
    localparam int TIMEOUT   = 8;

    logic             sys_clk;
    logic             sys_rst_n;
    logic [N_REQ-1:0] grant;
    logic             busy;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(
        .N_REQ    (N_REQ),
        .MAX_BURST(MAX_BURST),
        .TIMEOUT  (TIMEOUT),
        .HDR_EN   (1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .arb_bus  (bus),
        .grant    (grant),
        .busy     (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec  = 0;
    int n_err  = 0;

    // Per-requester byte queues: bit 8 marks the last byte of a packet
    logic [8:0]       mem [N_REQ][16];
    int               hd  [N_REQ];
    int               tl  [N_REQ];
    logic [N_REQ-1:0] en;
    logic [7:0]       got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N_REQ; i++) begin
            if (en[i] && hd[i] < tl[i]) begin
                bus.req_valid[i]        = 1'b1;
                bus.req_data[8*i +: 8]  = mem[i][hd[i]][7:0];
                bus.req_last[i]         = mem[i][hd[i]][8];
            end else begin
                bus.req_valid[i]        = 1'b0;
                bus.req_data[8*i +: 8]  = 8'h00;
                bus.req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        mem[r][tl[r]] = {last, d};
        tl[r]++;
        drive_reqs();
    endtask

    // One clock: sample the settled cycle, cross the edge, advance requester queues
    task automatic tick();
        logic [N_REQ-1:0] cons;
        #1;
        cons = bus.req_ready & bus.req_valid;
        if (bus.tx_ready && bus.tx_ack) got.push_back(bus.tx_data);
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < N_REQ; i++)
            if (cons[i]) hd[i]++;
        drive_reqs();
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        en = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        drive_reqs();
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        got.delete();
    endtask

    task automatic run_until(input int n, input int budget);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    initial begin
        logic [7:0]       exp3 [12];
        logic [N_REQ-1:0] exp_g;
        logic             bad;

        sys_rst_n   = 1'b0;
        bus.tx_ack  = 1'b1;
        en          = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        drive_reqs();
        #12;
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
        chk("rst_req_ready",32'(bus.req_ready),32'd0);
        chk("rst_grant",    32'(grant),        32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        @(posedge sys_clk);
        do_reset();

        // Single requester 2, three bytes with a header
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        en[2] = 1'b1;
        drive_reqs();
        bad = 1'b0;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            tick();
            if (busy && grant !== 4'b0100) bad = 1'b1;
        end
        chk("t1_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("t1_b0", 32'(got[0]), 32'hF2);
            chk("t1_b1", 32'(got[1]), 32'h11);
            chk("t1_b2", 32'(got[2]), 32'h22);
            chk("t1_b3", 32'(got[3]), 32'h33);
        end
        chk("t1_grant_held", 32'(bad), 32'd0);
        chk("t1_idle_busy",  32'(busy), 32'd0);
        chk("t1_idle_grant", 32'(grant), 32'd0);
        chk("t1_ptr",        32'(dut.ptr_q), 32'd3);

        // Round robin with single-byte packets from a fresh ptr of 0
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            push(i, 8'hA0 + 8'(i), 1'b1);
            push(i, 8'hB0 + 8'(i), 1'b1);
        end
        en = 4'b1111;
        drive_reqs();
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp_g = '0;
            if (k % 3 != 0) exp_g[((k - 1) / 3) % N_REQ] = 1'b1;
            chk($sformatf("t2_grant_k%0d", k), 32'(grant), 32'(exp_g));
        end
        chk("t2_count", 32'(got.size()), 32'd10);
        if (got.size() == 10) begin
            chk("t2_h0", 32'(got[0]), 32'hF0);
            chk("t2_d0", 32'(got[1]), 32'hA0);
            chk("t2_d3", 32'(got[7]), 32'hA3);
            chk("t2_h4", 32'(got[8]), 32'hF0);
            chk("t2_d4", 32'(got[9]), 32'hB0);
        end

        // Burst limit of 4 bytes: requester 1 streams, requester 3 waits its turn
        do_reset();
        for (int b = 1; b <= 10; b++) push(1, 8'(b), 1'b0);
        push(3, 8'h3C, 1'b1);
        en = 4'b1010;
        drive_reqs();
        exp3 = '{8'hF1, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF3, 8'h3C,
                 8'hF1, 8'h05, 8'h06, 8'h07, 8'h08};
        run_until(12, 60);
        chk("t3_count", 32'(got.size()), 32'd12);
        if (got.size() == 12)
            for (int j = 0; j < 12; j++)
                chk($sformatf("t3_b%0d", j), 32'(got[j]), 32'(exp3[j]));

        // Timeout of 8 idle cycles after one byte
        do_reset();
        push(0, 8'h55, 1'b0);
        en = 4'b0001;
        drive_reqs();
        run_until(2, 10);
        chk("t4_count", 32'(got.size()), 32'd2);
        for (int c = 0; c < 7; c++) tick();
        chk("t4_grant_7", 32'(grant), 32'h1);
        tick();
        chk("t4_grant_8", 32'(grant), 32'h0);
        chk("t4_busy_8",  32'(busy),  32'd0);

        // DATA backpressure with valid held high never times out
        push(0, 8'h77, 1'b0);
        push(0, 8'h66, 1'b1);
        got.delete();
        run_until(2, 10);
        bus.tx_ack = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (grant !== 4'b0001 || !busy) bad = 1'b1;
        end
        chk("t4_no_timeout", 32'(bad), 32'd0);
        bus.tx_ack = 1'b1;
        tick();
        chk("t4_bp_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) chk("t4_bp_byte", 32'(got[2]), 32'h66);
        chk("t4_bp_idle", 32'(busy), 32'd0);

        // Header backpressure for 20 cycles
        do_reset();
        bus.tx_ack = 1'b0;
        push(3, 8'h99, 1'b1);
        en = 4'b1000;
        drive_reqs();
        tick();
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.tx_ready !== 1'b1 || bus.tx_data !== 8'hF3 || bus.req_ready !== 4'b0000)
                bad = 1'b1;
            tick();
        end
        chk("t5_hdr_hold", 32'(bad), 32'd0);
        bus.tx_ack = 1'b1;
        run_until(2, 6);
        chk("t5_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t5_hdr",  32'(got[0]), 32'hF3);
            chk("t5_data", 32'(got[1]), 32'h99);
        end

        // Asynchronous reset in the middle of a DATA burst
        do_reset();
        push(0, 8'h5A, 1'b1);
        en = 4'b0001;
        drive_reqs();
        run_until(2, 8);
        tick();
        for (int b = 0; b < 5; b++) push(2, 8'hC0 + 8'(b), 1'b0);
        en = 4'b0100;
        drive_reqs();
        run_until(4, 10);
        chk("t6_pre_ready", 32'(bus.tx_ready), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t6_tx_ready",  32'(bus.tx_ready),  32'd0);
        chk("t6_tx_data",   32'(bus.tx_data),   32'd0);
        chk("t6_req_ready", 32'(bus.req_ready), 32'd0);
        chk("t6_grant",     32'(grant),         32'd0);
        chk("t6_busy",      32'(busy),          32'd0);
        @(posedge sys_clk);
        #1;
        chk("t6_hold_ready", 32'(bus.req_ready), 32'd0);
        do_reset();
        push(0, 8'hE0, 1'b1);
        push(1, 8'hE1, 1'b1);
        en = 4'b0011;
        drive_reqs();
        tick();
        chk("t6_restart_grant", 32'(grant), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART byte transmitter among `N_REQ` byte-stream requesters. It sits between the requesters and the transmitter's `tx_data`/`tx_ready`/`tx_ack` byte port. A grant is held for one packet: until the requester's `req_last`, `MAX_BURST` bytes, or an idle timeout. Each burst is optionally prefixed with a header byte that identifies the source, so the far end can demultiplex the streams.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 16: maximum data bytes per grant (1..256).
- `TIMEOUT`, 255: cycles a granted requester may hold `req_valid` low before the grant is revoked (1..65535).
- `HDR_EN`, 1: when 1, emit a header byte `{5'b11110, id[2:0]}` before each burst.

Ports:
- `sys_clk`  in  1: clock; all logic is rising-edge.
- `sys_rst_n`  in  1: asynchronous reset, active low.
- `req_valid`  in  `N_REQ`: requester i presents a byte.
- `req_data`  in  `8*N_REQ`: byte of requester i in bits [8i+7:8i].
- `req_last`  in  `N_REQ`: the presented byte ends requester i's packet.
- `req_ready`  out  `N_REQ`: byte of requester i is consumed this cycle.
- `tx_data`  out  8: byte to the transmitter.
- `tx_ready`  out  1: `tx_data` is valid.
- `tx_ack`  in  1: transmitter is idle and accepts a byte.
- `grant`  out  `N_REQ`: one-hot current owner; all zeros when idle.
- `busy`  out  1: state is not IDLE.

## Operation
- A byte transfers on any cycle where `tx_ready` and `tx_ack` are both 1.
- States are IDLE, HDR and DATA. Registers:
  - `state`
  - `grant`
  - `ptr` (next priority index, `clog2(N_REQ)` bits)
  - `bcnt` (burst count, `clog2(MAX_BURST+1)` bits)
  - `tcnt` (timeout count, 16 bits)
- IDLE:
  - Outputs `tx_ready`=0, `tx_data`=0 and `req_ready`=0.
  - If any `req_valid` is 1, select the first set bit searching `ptr`, `ptr+1`, … modulo `N_REQ`.
  - Register the selection as one-hot `grant` and its index `gid`.
  - Clear `bcnt` and `tcnt`.
  - Go to HDR if `HDR_EN`=1, else DATA.
- HDR:
  - `tx_ready`=1 and `tx_data`={5'b11110, `gid`}. These do not depend on `req_valid`.
  - On transfer, go to DATA.
- DATA:
  - `tx_ready`=`req_valid[gid]`, `tx_data`=`req_data[gid]`.
  - `req_ready[gid]`=`tx_ack`; all other `req_ready` bits are 0.
  - On transfer:
    - `bcnt`+1 and `tcnt` cleared.
    - If `req_last[gid]`=1 or `bcnt`==`MAX_BURST`-1, go to IDLE.
  - When `req_valid[gid]`=0:
    - `tcnt`+1.
    - When `tcnt`==`TIMEOUT`-1, go to IDLE without a transfer.
  - `tcnt` also holds when `req_valid`=1 and `tx_ack`=0. Transmitter backpressure never times out.
- Every exit to IDLE:
  - `grant` cleared.
  - `ptr`=(`gid`+1) mod `N_REQ`, so the last owner becomes lowest priority.
- Requesters not granted are never given `req_ready`. Their `req_valid` is ignored outside the IDLE decision.
- An unused or invalid `state` encoding returns to IDLE.

## Timing
- Reset (asynchronous, `sys_rst_n`=0):
  - `state`=IDLE, `grant`=0, `ptr`=0, `bcnt`=0, `tcnt`=0.
  - Outputs `tx_ready`=0, `tx_data`=0, `req_ready`=0 and `busy`=0.
- Release is synchronous to `sys_clk`; the first decision is made on the first edge with `sys_rst_n`=1.
- Reset mid-burst abandons the burst immediately; no further `req_ready` is asserted.
- Arbitration latency: `req_valid` sampled in IDLE gives `grant` and `busy` at the next edge.
  - First offered byte (header, or data when `HDR_EN`=0) appears in the cycle after the decision.
- `tx_data`, `tx_ready` and `req_ready` are combinational from registered state plus `req_valid`, `req_data` and `tx_ack`. There is no pass-through register, so a byte is consumed in the cycle it transfers.
- The arbiter does no flow control of its own; a new transfer waits until the transmitter raises `tx_ack` again.
- Back-to-back grants: each burst end costs one IDLE cycle. Each burst carries at most `MAX_BURST` data bytes plus one header.
- Simultaneous `req_last` and `bcnt` limit: single exit to IDLE, same `ptr` update.
- `req_last` is ignored in HDR and when `req_valid[gid]`=0.
- `ptr` wraps from `N_REQ`-1 to 0.

## Test plan
- Reset, single requester: `N_REQ`=4, `HDR_EN`=1, `tx_ack`=1; requester 2 sends 3 bytes with `req_last` on 0x33.
  - Required: transfers 0xF2, 0x11, 0x22, 0x33.
  - Required: `grant`=4'b0100 throughout, then IDLE with `ptr`=3.
- Round robin: all four requesters continuously valid with single-byte packets (`req_last`=1) and `tx_ack`=1.
  - Required grant order 0,1,2,3,0.
  - Required: each grant is separated by exactly one IDLE cycle.
- Burst limit: `MAX_BURST`=4; requester 1 streams 10 bytes with no `req_last` while requester 3 is valid.
  - Required: after 4 data bytes, grant passes to requester 3.
  - Required: requester 1 resumes on its next turn, sending bytes 5..8.
- Timeout: `TIMEOUT`=8; requester 0 sends one byte, then drops `req_valid`.
  - Required: return to IDLE exactly 8 cycles later with `grant`=0.
  - Required: with `tx_ack`=0 and `req_valid`=1 held for 100 cycles, no timeout occurs.
- Backpressure: `tx_ack` is low for 20 cycles during HDR.
  - Required: `tx_ready`=1 and `tx_data` held steady.
  - Required: no `req_ready` is asserted until the header transfers.
- Reset mid-DATA: assert `sys_rst_n`=0 asynchronously between edges.
  - Required: all outputs go to 0 immediately.
  - Required: after release, arbitration restarts from `ptr`=0.
